mem_arbiter: RTL and testbench

- Sequences the single-port instruction/data Ram between two requesters: the Fetch stage (read-only) and the Memory stage (loads/stores).
- Grants one requester at a time and drives the Ram address, data and wre lines.
- Returns read data with a one-cycle acknowledge pulse.
- Produces the fetch stall while an instruction read is outstanding.
- Memory stage has priority; a streak limiter guarantees Fetch forward progress.

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port Ram between Fetch (read-only) and the
// Memory stage (loads/stores). Memory stage has priority; a streak limiter
// forces a Fetch grant after MAX_STREAK consecutive MEM grants while Fetch waits.
//
// Handshake: a requester raises req with addr (and we/wdata) and holds them
// until it samples its ack high at a rising edge. ack is a one-cycle pulse and
// the matching rdata is valid in that cycle. Requests are only evaluated in
// IDLE, so each transaction is IDLE + LATENCY x ACCESS + DONE cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wre,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_mem, grant_if, access_last;
  logic                owner_mem_q, we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;

  assign if_stall  = if_req & ~if_ack;
  assign dbg_state = state_q;

  // Next-state and grant decision; grants are only made from IDLE.
  always_comb begin
    state_d     = state_q;
    grant_mem   = 1'b0;
    grant_if    = 1'b0;
    access_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && (!if_req || streak_q != STREAK_MAX)) begin
          grant_mem = 1'b1;
          state_d   = ACCESS;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          access_last = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch the granted transaction and drive the Ram; wre drops only for a MEM store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wre     <= 1'b1;
    end else if (grant_mem) begin
      owner_mem_q <= 1'b1;
      we_q        <= mem_we;
      ram_addr    <= mem_addr;
      ram_wdata   <= mem_wdata;
      ram_wre     <= ~mem_we;
      cnt_q       <= CNT_LOAD;
    end else if (grant_if) begin
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      ram_addr    <= if_addr;
      ram_wre     <= 1'b1;
      cnt_q       <= CNT_LOAD;
    end else if (state_q == ACCESS) begin
      if (cnt_q == '0) ram_wre <= 1'b1;
      else             cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  // Completion: capture read data and raise the owner's ack for the DONE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (access_last) begin
        if (owner_mem_q) begin
          mem_ack <= 1'b1;
          if (!we_q) mem_rdata <= ram_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= ram_rdata;
        end
      end
    end
  end

  // Streak of MEM grants taken while Fetch was waiting; saturates at MAX_STREAK.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_if || !if_req)                      streak_q <= '0;
      else if (grant_mem && streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (LATENCY=1 as "a", LATENCY=3 as "b"),
// each attached to a behavioural Ram with combinational read and clocked write.
module tb_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic          a_if_req, a_if_ack, a_if_stall, a_mem_req, a_mem_we, a_mem_ack, a_ram_wre;
  logic [AW-1:0] a_if_addr, a_mem_addr, a_ram_addr;
  logic [DW-1:0] a_if_rdata, a_mem_wdata, a_mem_rdata, a_ram_wdata, a_ram_rdata;
  logic [1:0]    a_dbg_state;
  logic          b_if_req, b_if_ack, b_if_stall, b_mem_req, b_mem_we, b_mem_ack, b_ram_wre;
  logic [AW-1:0] b_if_addr, b_mem_addr, b_ram_addr;
  logic [DW-1:0] b_if_rdata, b_mem_wdata, b_mem_rdata, b_ram_wdata, b_ram_rdata;
  logic [1:0]    b_dbg_state;

  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] ram_a [0:511];
  logic [DW-1:0] ram_b [0:511];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  // Clock and reset-free watchdog.
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .MAX_STREAK(3)) u_a (
    .clock(clock), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack), .if_stall(a_if_stall),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .ram_wre(a_ram_wre),
    .dbg_state(a_dbg_state)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(3), .MAX_STREAK(3)) u_b (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack), .if_stall(b_if_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .ram_wre(b_ram_wre),
    .dbg_state(b_dbg_state)
  );

  // Ram models: read is combinational, write lands at the rising edge while wre=0.
  assign a_ram_rdata = ram_a[a_ram_addr];
  assign b_ram_rdata = ram_b[b_ram_addr];
  always @(posedge clock) begin
    if (pl_we)           ram_a[pl_addr]    <= pl_data;
    else if (!a_ram_wre) ram_a[a_ram_addr] <= a_ram_wdata;
    if (!b_ram_wre)      ram_b[b_ram_addr] <= b_ram_wdata;
  end

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pl_we = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  // Collects the owner order of n acks on instance a: bit k = 1 when the k-th ack was Fetch.
  task automatic collect_acks(input int n, output logic [7:0] seq, output int got, output int overlaps);
    int cyc;
    cyc = 0; seq = '0; got = 0; overlaps = 0;
    while (got < n && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (a_if_ack === 1'b1 && a_mem_ack === 1'b1) overlaps++;
      if (a_if_ack === 1'b1) begin seq[got[2:0]] = 1'b1; got++; end
      else if (a_mem_ack === 1'b1) begin seq[got[2:0]] = 1'b0; got++; end
    end
  endtask

  task automatic test_reset();
    preload(9'h004, 32'h8C01_0000);
    preload(9'h020, 32'h0BAD_0BAD);
    n_tests++; if (a_ram_wre !== 1'b1) begin n_fail++; $display("FAIL reset_ram_wre: got %0b want 1", a_ram_wre); end
    n_tests++; if (a_if_ack !== 1'b0 || a_mem_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got if=%0b mem=%0b want 0 0", a_if_ack, a_mem_ack); end
    n_tests++; if (a_if_rdata !== '0 || a_mem_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got if=%h mem=%h want 0 0", a_if_rdata, a_mem_rdata); end
    n_tests++; if (a_ram_addr !== '0 || a_ram_wdata !== '0) begin n_fail++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h want 0 0", a_ram_addr, a_ram_wdata); end
    n_tests++; if (b_if_rdata !== '0 || b_if_stall !== 1'b0 || b_ram_wre !== 1'b1) begin n_fail++; $display("FAIL reset_b: got rdata=%h stall=%0b wre=%0b want 0 0 1", b_if_rdata, b_if_stall, b_ram_wre); end
    reset = 1'b1;
    @(negedge clock);
    n_tests++; if (a_dbg_state !== 2'd0 || b_dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got a=%0d b=%0d want 0 0", a_dbg_state, b_dbg_state); end
  endtask

  task automatic test_fetch();
    int cyc; bit seen; bit wre_ok; bit stall_ok; logic [DW-1:0] exp;
    a_if_req = 1'b1; a_if_addr = 9'h004;
    exp_q.push_back(32'h8C01_0000);
    #1;
    n_tests++; if (a_if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_rise: got %0b want 1", a_if_stall); end
    cyc = 0; seen = 0; wre_ok = 1; stall_ok = 1;
    while (!seen && cyc < 20) begin
      @(negedge clock); cyc++;
      if (a_ram_wre !== 1'b1) wre_ok = 0;
      if (a_if_ack === 1'b1) seen = 1;
      else if (a_if_stall !== 1'b1) stall_ok = 0;
    end
    n_tests++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL fetch_latency: got ack=%0b after %0d cycles want 1 after 2", seen, cyc); end
    n_tests++; if (!wre_ok) begin n_fail++; $display("FAIL fetch_wre: got a write cycle want ram_wre=1 throughout"); end
    n_tests++; if (!stall_ok || a_if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall: got held=%0b ack_cycle=%0b want 1 0", stall_ok, a_if_stall); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL fetch_sb: got empty queue want one entry"); end
    else begin
      exp = exp_q.pop_front();
      if (a_if_rdata !== exp) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", a_if_rdata, exp); end
    end
    a_if_req = 1'b0;
    @(negedge clock);
    n_tests++; if (a_if_ack !== 1'b0 || a_if_rdata !== 32'h8C01_0000) begin n_fail++; $display("FAIL fetch_pulse_hold: got ack=%0b rdata=%h want 0 8c010000", a_if_ack, a_if_rdata); end
  endtask

  task automatic test_store_load();
    int cyc; bit seen; int wre0; bit wre0_late; logic [DW-1:0] exp;
    a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_addr = 9'h010; a_mem_wdata = 32'hDEAD_BEEF;
    cyc = 0; seen = 0; wre0 = 0; wre0_late = 0;
    while (!seen && cyc < 20) begin
      @(negedge clock); cyc++;
      if (a_ram_wre === 1'b0) begin wre0++; if (cyc != 1) wre0_late = 1; end
      if (a_mem_ack === 1'b1) seen = 1;
    end
    n_tests++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL store_latency: got ack=%0b after %0d cycles want 1 after 2", seen, cyc); end
    n_tests++; if (wre0 != 1 || wre0_late) begin n_fail++; $display("FAIL store_wre: got %0d low cycles (outside ACCESS=%0b) want 1 (0)", wre0, wre0_late); end
    n_tests++; if (a_mem_rdata !== '0 || a_if_ack !== 1'b0) begin n_fail++; $display("FAIL store_rdata: got mem_rdata=%h if_ack=%0b want 0 0", a_mem_rdata, a_if_ack); end
    n_tests++; if (ram_a[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_ram: got %h want deadbeef", ram_a[16]); end
    // Same requester turns the store into a load after sampling the ack.
    a_mem_we = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clock);
    n_tests++; if (a_mem_ack !== 1'b0 || a_mem_rdata !== '0) begin n_fail++; $display("FAIL store_after: got ack=%0b rdata=%h want 0 0", a_mem_ack, a_mem_rdata); end
    cyc = 1; seen = 0; wre0 = 0;
    while (!seen && cyc < 20) begin
      @(negedge clock); cyc++;
      if (a_ram_wre === 1'b0) wre0++;
      if (a_mem_ack === 1'b1) seen = 1;
    end
    n_tests++; if (!seen || cyc != 3 || wre0 != 0) begin n_fail++; $display("FAIL load_timing: got ack=%0b cycles=%0d wre_low=%0d want 1 3 0", seen, cyc, wre0); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL load_sb: got empty queue want one entry"); end
    else begin
      exp = exp_q.pop_front();
      if (a_mem_rdata !== exp) begin n_fail++; $display("FAIL load_rdata: got %h want %h", a_mem_rdata, exp); end
    end
    a_mem_req = 1'b0;
    @(negedge clock);
    n_tests++; if (a_mem_ack !== 1'b0 || a_mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_hold: got ack=%0b rdata=%h want 0 deadbeef", a_mem_ack, a_mem_rdata); end
  endtask

  task automatic test_contention();
    logic [7:0] seq; int got; int ovl;
    a_if_req = 1'b1; a_if_addr = 9'h004;
    a_mem_req = 1'b1; a_mem_we = 1'b0; a_mem_addr = 9'h010;
    collect_acks(8, seq, got, ovl);
    a_if_req = 1'b0; a_mem_req = 1'b0;
    n_tests++; if (got != 8) begin n_fail++; $display("FAIL contention_count: got %0d acks want 8", got); end
    n_tests++; if (seq !== 8'h88) begin n_fail++; $display("FAIL contention_order: got %b want 10001000 (bit0 first, 1=IF)", seq); end
    n_tests++; if (ovl != 0) begin n_fail++; $display("FAIL contention_overlap: got %0d overlapping cycles want 0", ovl); end
    n_tests++; if (a_if_rdata !== 32'h8C01_0000 || a_mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL contention_data: got if=%h mem=%h want 8c010000 deadbeef", a_if_rdata, a_mem_rdata); end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] seq; int got; int ovl; bit ack_seen;
    a_if_req = 1'b1; a_if_addr = 9'h004;
    a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_addr = 9'h020; a_mem_wdata = 32'h1234_5678;
    @(negedge clock);
    n_tests++; if (a_ram_wre !== 1'b0) begin n_fail++; $display("FAIL abort_inflight: got wre=%0b want 0", a_ram_wre); end
    reset = 1'b0;
    #1;
    n_tests++; if (a_ram_wre !== 1'b1 || a_dbg_state !== 2'd0) begin n_fail++; $display("FAIL abort_immediate: got wre=%0b state=%0d want 1 0", a_ram_wre, a_dbg_state); end
    a_if_req = 1'b0; a_mem_req = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (a_mem_ack !== 1'b0) ack_seen = 1;
    end
    n_tests++; if (ack_seen) begin n_fail++; $display("FAIL abort_ack: got mem_ack during reset want none"); end
    n_tests++; if (ram_a[32] !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL abort_ram: got %h want 0bad0bad", ram_a[32]); end
    reset = 1'b1;
    @(negedge clock);
    // Re-issue with Fetch also waiting: a cleared streak gives three MEM grants first.
    a_if_req = 1'b1; a_mem_req = 1'b1;
    collect_acks(4, seq, got, ovl);
    a_if_req = 1'b0; a_mem_req = 1'b0;
    n_tests++; if (got != 4 || seq[3:0] !== 4'b1000 || ovl != 0) begin n_fail++; $display("FAIL abort_reissue: got n=%0d order=%b overlap=%0d want 4 1000 0", got, seq[3:0], ovl); end
    n_tests++; if (ram_a[32] !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_complete: got %h want 12345678", ram_a[32]); end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_latency3();
    int cyc; bit seen; int wre0; bit addr_ok; bit if_quiet; logic [DW-1:0] exp;
    b_mem_req = 1'b1; b_mem_we = 1'b1; b_mem_addr = 9'h030; b_mem_wdata = 32'hA5A5_0001;
    cyc = 0; seen = 0; wre0 = 0; addr_ok = 1; if_quiet = 1;
    while (!seen && cyc < 30) begin
      @(negedge clock); cyc++;
      if (b_ram_addr !== 9'h030) addr_ok = 0;
      if (b_ram_wre === 1'b0) wre0++;
      if (b_if_ack !== 1'b0) if_quiet = 0;
      if (b_mem_ack === 1'b1) seen = 1;
    end
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL lat3_store_latency: got ack=%0b after %0d cycles want 1 after 4", seen, cyc); end
    n_tests++; if (wre0 != 3 || !addr_ok) begin n_fail++; $display("FAIL lat3_access: got wre_low=%0d addr_stable=%0b want 3 1", wre0, addr_ok); end
    b_mem_we = 1'b0;
    exp_q.push_back(32'hA5A5_0001);
    cyc = 0; seen = 0; wre0 = 0;
    while (!seen && cyc < 30) begin
      @(negedge clock); cyc++;
      if (cyc >= 2 && b_ram_addr !== 9'h030) addr_ok = 0;
      if (b_ram_wre === 1'b0) wre0++;
      if (b_if_ack !== 1'b0) if_quiet = 0;
      if (b_mem_ack === 1'b1) seen = 1;
    end
    n_tests++; if (!seen || cyc != 5 || wre0 != 0 || !addr_ok) begin n_fail++; $display("FAIL lat3_load: got ack=%0b span=%0d wre_low=%0d addr_stable=%0b want 1 5 0 1", seen, cyc, wre0, addr_ok); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL lat3_sb: got empty queue want one entry"); end
    else begin
      exp = exp_q.pop_front();
      if (b_mem_rdata !== exp) begin n_fail++; $display("FAIL lat3_rdata: got %h want %h", b_mem_rdata, exp); end
    end
    b_mem_req = 1'b0;
    @(negedge clock);
    n_tests++; if (b_mem_ack !== 1'b0 || !if_quiet) begin n_fail++; $display("FAIL lat3_pulse: got mem_ack=%0b if_quiet=%0b want 0 1", b_mem_ack, if_quiet); end
  endtask

  initial begin
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    a_if_req = 1'b0; a_if_addr = '0; a_mem_req = 1'b0; a_mem_we = 1'b0; a_mem_addr = '0; a_mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_reset_mid_access();
    test_latency3();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d leftover entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
